// File: rtl/audio_channel_arbiter.sv
// audio_channel_arbiter: shares one PWM audio DAC sample path among N_REQ sources.
// Round-robin req/grant arbiter. Minimum and maximum grant durations are counted
// in sample ticks. Between owners, a midscale (silence) guard gap is inserted.
//
// Ports:
//   sysclk      - system clock
//   reset_n     - asynchronous active-low reset
//   sample_tick - one-cycle strobe at the audio sample rate
//   req         - per-channel level request
//   sample_in   - channel i sample at [i*SAMPLE_W +: SAMPLE_W]
//   grant       - one-hot or zero, registered
//   sample_out  - sample to the PWM modulator, registered
//   active      - high while a channel owns the grant
//
// Optional feature macro: AUD_ARB_PRIO0_EN
//   When this macro is defined, channel 0 is an alert channel. A rising req[0]
//   pre-empts the current owner immediately and skips the guard gap. Channel 0
//   also wins every IDLE arbitration.
module audio_channel_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned SAMPLE_W    = 8,
    parameter int unsigned MIN_HOLD    = 256,
    parameter int unsigned MAX_HOLD    = 4096,
    parameter int unsigned GUARD_TICKS = 16
) (
    input  logic                      sysclk,
    input  logic                      reset_n,
    input  logic                      sample_tick,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*SAMPLE_W-1:0] sample_in,
    output logic [N_REQ-1:0]          grant,
    output logic [SAMPLE_W-1:0]       sample_out,
    output logic                      active
);

    localparam int unsigned HOLD_SAT = (MIN_HOLD > MAX_HOLD) ? MIN_HOLD : MAX_HOLD;
    localparam int unsigned CNT_MAX  = (HOLD_SAT > GUARD_TICKS) ? HOLD_SAT : GUARD_TICKS;
    localparam int unsigned CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int unsigned PTR_W    = $clog2(N_REQ);
    localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [PTR_W-1:0]    owner, owner_d;
    logic [PTR_W-1:0]    ptr, ptr_d;
    logic [CNT_W-1:0]    hold_cnt, hold_d;
    logic [CNT_W-1:0]    guard_cnt, guard_d;
    logic [N_REQ-1:0]    grant_d;
    logic [SAMPLE_W-1:0] sample_d;
    logic                active_d;

    logic [PTR_W-1:0]    sel;
    logic [PTR_W-1:0]    cand;
    logic                found;
    logic [SAMPLE_W-1:0] owner_sample;
    logic [PTR_W-1:0]    next_ptr;
    logic                release_now;
    logic                preempt_now;

`ifdef AUD_ARB_PRIO0_EN
    logic req0_q;
    logic alert_rise;

    // Edge detector for the alert channel request.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) req0_q <= 1'b0;
        else          req0_q <= req[0];
    end
    assign alert_rise = req[0] & ~req0_q;
`endif

    // Round-robin scan starting at ptr.
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = PTR_W'((32'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
`ifdef AUD_ARB_PRIO0_EN
        if (req[0]) begin
            sel   = '0;
            found = 1'b1;
        end
`endif
    end

    // Owner sample mux; constant slices keep index widths exact.
    always_comb begin
        owner_sample = MIDSCALE;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner == PTR_W'(i)) owner_sample = sample_in[i*SAMPLE_W +: SAMPLE_W];
        end
    end

    assign next_ptr    = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);
    assign release_now = !req[owner] && (hold_cnt >= CNT_W'(MIN_HOLD));
    assign preempt_now = (MAX_HOLD != 0) && (hold_cnt >= CNT_W'(MAX_HOLD))
                         && ((req & ~grant) != '0);

    // State register plus registered outputs and counters.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            owner      <= '0;
            ptr        <= '0;
            hold_cnt   <= '0;
            guard_cnt  <= '0;
            grant      <= '0;
            sample_out <= MIDSCALE;
            active     <= 1'b0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            ptr        <= ptr_d;
            hold_cnt   <= hold_d;
            guard_cnt  <= guard_d;
            grant      <= grant_d;
            sample_out <= sample_d;
            active     <= active_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        owner_d  = owner;
        ptr_d    = ptr;
        hold_d   = hold_cnt;
        guard_d  = guard_cnt;
        grant_d  = grant;
        sample_d = sample_out;
        active_d = active;

        case (state)
            ST_IDLE: begin
                grant_d  = '0;
                active_d = 1'b0;
                sample_d = MIDSCALE;
                if (found) begin
                    state_d  = ST_GRANT;
                    owner_d  = sel;
                    grant_d  = N_REQ'(1) << sel;
                    active_d = 1'b1;
                    hold_d   = '0;
                end
            end

            ST_GRANT: begin
`ifdef AUD_ARB_PRIO0_EN
                if (alert_rise && (owner != '0)) begin
                    // Alert pre-emption: no guard, channel 0 wins IDLE next cycle.
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    active_d = 1'b0;
                    sample_d = MIDSCALE;
                    ptr_d    = next_ptr;
                end else
`endif
                if (release_now || preempt_now) begin
                    state_d  = (GUARD_TICKS == 0) ? ST_IDLE : ST_GUARD;
                    grant_d  = '0;
                    active_d = 1'b0;
                    sample_d = MIDSCALE;
                    guard_d  = '0;
                    ptr_d    = next_ptr;
`ifdef AUD_ARB_PRIO0_EN
                    if (owner == '0) ptr_d = ptr;
`endif
                end else if (sample_tick) begin
                    sample_d = owner_sample;
                    if (hold_cnt < CNT_W'(HOLD_SAT)) hold_d = hold_cnt + CNT_W'(1);
                end
            end

            ST_GUARD: begin
                grant_d  = '0;
                active_d = 1'b0;
                sample_d = MIDSCALE;
                if (guard_cnt == CNT_W'(GUARD_TICKS)) begin
                    state_d = ST_IDLE;
                end else if (sample_tick) begin
                    guard_d = guard_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                active_d = 1'b0;
                sample_d = MIDSCALE;
            end
        endcase
    end

endmodule

// File: doc/audio_channel_arbiter.md
Name: audio_channel_arbiter

Overview:
- Shares one PWM audio DAC input among N_REQ tone/sample sources.
- Round-robin arbiter with a req/grant handshake, minimum and maximum grant durations counted in audio sample ticks, and a midscale-silence guard gap between owners.
- Sits between the per-channel tone generators and the single PWM modulator feeding a pwm_aud pin.

Parameters:
- N_REQ, 4: number of requesting channels (2..8).
- SAMPLE_W, 8: sample width; PWM silence code is 2^(SAMPLE_W-1).
- MIN_HOLD, 256: sample ticks a grant is held before a voluntary release is honoured.
- MAX_HOLD, 4096: sample ticks after which a grant is pre-empted if another channel is requesting. 0 disables pre-emption.
- GUARD_TICKS, 16: sample ticks of forced midscale between grants. 0 means no guard.

Ports:
- sysclk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_tick  in  1  one-cycle strobe at the audio sample rate
- req  in  N_REQ  per-channel request, level
- sample_in  in  N_REQ*SAMPLE_W  channel i at [i*SAMPLE_W +: SAMPLE_W]
- grant  out  N_REQ  one-hot or zero, registered
- sample_out  out  SAMPLE_W  to PWM modulator, registered
- active  out  1  high while in GRANT

Behaviour:
- One clock, sysclk. reset_n is asynchronous and active-low.
- Reset state:
  - FSM in IDLE, grant=0, active=0.
  - sample_out=2^(SAMPLE_W-1).
  - rr pointer=0, hold_cnt=0, guard_cnt=0.
- Reset asserted mid-grant takes effect immediately. There is no guard after reset.
- IDLE:
  - sample_out is held at midscale.
  - If req!=0, select the first set req scanning ptr, ptr+1, … mod N_REQ.
  - grant[sel] goes high on the next edge, active=1, hold_cnt=0, go to GRANT.
  - Latency from req rise (registered req seen) to grant is 1 cycle.
- GRANT, owner g:
  - On each sample_tick, sample_out <= sample_in[g] (1-cycle latency). Otherwise sample_out holds.
  - hold_cnt increments on each sample_tick and saturates at max(MIN_HOLD, MAX_HOLD).
  - Release: req[g]==0 && hold_cnt>=MIN_HOLD.
    - A req drop before MIN_HOLD is ignored; the grant and sample passthrough continue.
    - req[g] re-asserted before MIN_HOLD cancels the pending release.
  - Pre-empt: MAX_HOLD!=0 && hold_cnt>=MAX_HOLD && (req & ~grant)!=0.
    - A lone requester keeps its grant indefinitely.
  - On release or pre-empt, on the next edge:
    - grant=0, active=0, ptr=(g+1) mod N_REQ, sample_out=midscale.
    - Go to GUARD (guard_cnt=0), or to IDLE if GUARD_TICKS==0.
  - Release and pre-empt true in the same cycle are treated identically.
- GUARD:
  - sample_out is held at midscale; grant=0.
  - guard_cnt increments per sample_tick.
  - When guard_cnt==GUARD_TICKS, go to IDLE. Arbitration happens in IDLE on the following cycle.
  - req changes during GUARD are ignored.
- sample_tick coincident with a state change: the state change wins. No sample is latched on the exit edge.
- Counter width: clog2(max(MIN_HOLD, MAX_HOLD, GUARD_TICKS)+1).
- grant is never multi-hot.

Optional Feature:
- Macro: AUD_ARB_PRIO0_EN.
- When defined:
  - Channel 0 is an alert channel. If req[0] rises while another channel owns the grant, that owner is pre-empted on the next edge, regardless of MIN_HOLD.
  - The guard is skipped and grant goes straight to channel 0 one cycle later.
  - In IDLE, channel 0 wins regardless of ptr. ptr is not advanced when channel 0 releases.
- When undefined: channel 0 is an ordinary round-robin member and the logic is absent.

Test Plan:
Bench settings: N_REQ=4, MIN_HOLD=4, MAX_HOLD=16, GUARD_TICKS=2, SAMPLE_W=8, sample_tick every 4 cycles.
1. Reset: pulse reset_n low with random inputs -> grant=0, active=0, sample_out=0x80 asynchronously. After release with req=0, outputs are unchanged for 100 cycles.
2. Single request: req=4'b0100, sample_in[2]=0x3C -> grant=4'b0100 one cycle later. sample_out=0x3C one cycle after the next tick.
3. Early drop: req[2] drops after 1 tick -> grant held until hold_cnt=4, then grant=0. sample_out=0x80 for exactly 2 ticks, then IDLE.
4. Round-robin: req=4'b1111 held -> grants cycle 0001→0010→0100→1000→0001. Each grant lasts 16 ticks, with 2-tick midscale gaps.
5. Lone long request: req=4'b0001 only for 40 ticks -> grant=0001 is continuous, with no pre-emption.
6. (AUD_ARB_PRIO0_EN) Channel 1 owns the grant at hold_cnt=1 and req[0] rises -> grant=0 on the next edge, grant=0001 the following edge, and no midscale guard gap.
